mult32x32_fast_sched: RTL

- Scheduler and controller for the 32x32 fast multiplier arithmetic unit. The unit has 16-bit word select, a shifter, a product register, and MSW-zero flags.
- Arbitrates between two requesters and latches the granted operand pair.
- Sequences the unit's a_sel/b_sel/shift_sel/upd_prod/clr_prod controls, skipping partial products whose MSW is zero.
- Returns the 64-bit product with a per-requester done pulse. Sits between client logic and one shared arithmetic unit instance.

---
 rtl/mult32x32_fast_pkg.sv | 19 +
 rtl/mult32x32_fast_rr_arb.sv | 37 +++
 rtl/mult32x32_fast_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mult32x32_fast_pkg.sv
// Shared types and constants for the 32x32 fast multiplier scheduler.
package mult32x32_fast_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_A0B0,
        S_A1B0,
        S_A0B1,
        S_A1B1,
        S_DONE
    } state_t;

    localparam logic [1:0] SH0  = 2'd0;
    localparam logic [1:0] SH16 = 2'd1;
    localparam logic [1:0] SH32 = 2'd2;

    typedef logic owner_t;

endpackage

// File: rtl/mult32x32_fast_rr_arb.sv
// Two-way arbiter; round-robin pointer or fixed priority to requester 0.
module mult32x32_fast_rr_arb #(
    parameter bit ARB_RR = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (ARB_RR && ptr_q) begin
            if (req_i[1])      gnt_o = 2'b10;
            else if (req_i[0]) gnt_o = 2'b01;
        end else begin
            if (req_i[0])      gnt_o = 2'b01;
            else if (req_i[1]) gnt_o = 2'b10;
        end
    end

    // Pointer moves to the loser so it wins the next contention.
    always_comb begin
        ptr_d = ptr_q;
        if (ARB_RR && accept_i && (|gnt_o))
            ptr_d = gnt_o[0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) ptr_q <= 1'b0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mult32x32_fast_sched.sv
// Scheduler for the shared 32x32 fast multiplier; skips zero-MSW
// partial products and returns the product to the granted requester.
module mult32x32_fast_sched
    import mult32x32_fast_pkg::*;
#(
    parameter bit ARB_RR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic [1:0]  done,
    output logic [63:0] result,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        a_sel,
    output logic        b_sel,
    output logic [1:0]  shift_sel,
    output logic        upd_prod,
    output logic        clr_prod,
    input  logic        a_msw_is_0,
    input  logic        b_msw_is_0,
    input  logic [63:0] product
);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [1:0]  arb_gnt;
    logic        accept;

    mult32x32_fast_rr_arb #(
        .ARB_RR (ARB_RR)
    ) u_arb (
        .clk_i    (clk),
        .reset_i  (reset),
        .req_i    (req),
        .accept_i (accept),
        .gnt_o    (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        accept    = 1'b0;
        gnt       = 2'b00;
        done      = 2'b00;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        shift_sel = SH0;
        upd_prod  = 1'b0;
        clr_prod  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    accept   = 1'b1;
                    gnt      = arb_gnt;
                    clr_prod = 1'b1;
                    owner_d  = arb_gnt[1];
                    op_a_d   = arb_gnt[1] ? a1 : a0;
                    op_b_d   = arb_gnt[1] ? b1 : b0;
                    state_d  = S_A0B0;
                end
            end
            S_A0B0: begin
                upd_prod = 1'b1;
                if (!a_msw_is_0)      state_d = S_A1B0;
                else if (!b_msw_is_0) state_d = S_A0B1;
                else                  state_d = S_DONE;
            end
            S_A1B0: begin
                a_sel     = 1'b1;
                shift_sel = SH16;
                upd_prod  = 1'b1;
                state_d   = !b_msw_is_0 ? S_A0B1 : S_DONE;
            end
            S_A0B1: begin
                b_sel     = 1'b1;
                shift_sel = SH16;
                upd_prod  = 1'b1;
                state_d   = !a_msw_is_0 ? S_A1B1 : S_DONE;
            end
            S_A1B1: begin
                a_sel     = 1'b1;
                b_sel     = 1'b1;
                shift_sel = SH32;
                upd_prod  = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done    = owner_q ? 2'b10 : 2'b01;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    // Product register is only cleared on grant, so result holds after done.
    assign result = product;
    assign busy   = (state_q != S_IDLE) || accept;
    assign op_a   = op_a_q;
    assign op_b   = op_b_q;

endmodule
